muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit for the pipelined MIPS CPU's EX stage. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers.
- Sits beside the ALU and takes the same forwarded operand pair from the ID/EX register.
- Its HI/LO outputs feed the EX-stage result mux for MFHI/MFLO.
- `busy` drives the hazard unit's stall.

## Interface
Parameters:
- none (width fixed at 32).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  launch operation in `op` with operands `a`, `b`
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- wr_hi  in  1  MTHI: load HI from `a`
- wr_lo  in  1  MTLO: load LO from `a`
- cancel  in  1  pipeline flush; abort in-flight operation
- busy  out  1  operation in progress; stall MFHI/MFLO/MT*/new MULT/DIV
- done  out  1  one-cycle pulse; HI/LO hold the new result
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- FSM states:
  - IDLE: `start` → CALC (iterative) or FIX (fast multiply); latch operands as absolute values, record sign info.
  - CALC: 32 iterations counted by a 5-bit counter; the count-31 iteration → FIX.
  - FIX: apply signs, write HI/LO → DONE.
  - DONE: `done`=1; behaves as IDLE, so it accepts `start` and `wr_*`.
- Multiply: radix-2 shift-add on magnitudes, 64-bit product; negate if signed and operand signs differ. hi=product[63:32], lo=product[31:0].
- Divide: restoring, unsigned magnitudes. lo=quotient, hi=remainder.
  - Quotient negative iff signed and signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero, both signed and unsigned: lo=0xFFFFFFFF, hi=a (original value).
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- `start` while busy: ignored.
- `wr_hi`/`wr_lo`:
  - Applied at the edge when state is IDLE or DONE.
  - Ignored while busy.
  - Both asserted: both written.
- `start` together with `wr_*` in IDLE: both take effect; the operation's FIX later overwrites HI/LO.
- `cancel`: any state → IDLE at the next edge. HI/LO unchanged, no `done`. `cancel` overrides a simultaneous `start`.
- Reset (any time, including mid-operation): state IDLE, counter 0, hi=0, lo=0, busy=0, done=0.

## Timing
- `start` sampled at edge E0 (iterative path):
  - busy=1 for exactly 33 cycles: 32 CALC cycles + 1 FIX cycle.
  - HI/LO update on the edge closing FIX (E33).
  - done=1 and busy=0 in the following cycle.
- Back-to-back: a `start` during the DONE cycle is accepted; busy reasserts the next cycle.
- `busy` and `done` are registered, decoded from state only, with no combinational path from inputs.
- MFHI/MFLO may read hi/lo combinationally in any cycle with busy=0.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU bypass CALC; a single-cycle 64-bit product is computed into FIX.
  - busy=1 for 1 cycle; done in the cycle after that.
  - DIV/DIVU unchanged.
- Not defined: all four operations use the 33-cycle iterative path.

## Test plan
- MULT a=0xFFFFFFFF, b=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy 33 cycles (1 with `MULDIV_FAST_MUL_EN`), single done pulse.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0xAAAA5555, then DIV started. Assert `cancel` on cycle 10 → IDLE next cycle, hi=0xAAAA5555, no done. Deassert rst_n mid-operation → hi=lo=0, busy=0 immediately.
- `start` asserted while busy → no effect on result or timing. MTLO while busy → lo unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle MULT/MULTU product.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        sgn;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_cand;
  logic [33:0] div_diff;
  logic [63:0] prod_fix;

  always_comb begin
    sgn      = ~op[0];
    mag_a    = (sgn && a[31]) ? (32'd0 - a) : a;
    mag_b    = (sgn && b[31]) ? (32'd0 - b) : b;
    mul_sum  = {1'b0, acc_q[63:32]}
             + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    div_cand = acc_q[63:31];
    div_diff = {1'b0, div_cand} - {2'b00, opnd_q};
    prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (wr_hi) hi_d = a;
        if (wr_lo) lo_d = a;
        if (start) begin
          state_d   = CALC;
          cnt_d     = 5'd0;
          is_div_d  = op[1];
          acc_d     = {32'd0, (op[1] ? mag_a : mag_b)};
          opnd_d    = op[1] ? mag_b : mag_a;
          // x/0 keeps quotient all-ones and remainder equal to a
          neg_res_d = sgn & (a[31] ^ b[31])
                    & (~op[1] | (b != 32'd0));
          neg_rem_d = sgn & a[31];
`ifdef MULDIV_FAST_MUL_EN
          if (!op[1]) begin
            state_d = FIX;
            acc_d   = {32'd0, mag_a} * {32'd0, mag_b};
          end
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          if (!div_diff[33])
            acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
          else
            acc_d = {div_cand[31:0], acc_q[30:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (is_div_q) begin
          hi_d = neg_rem_q ? (32'd0 - acc_q[63:32])
                           : acc_q[63:32];
          lo_d = neg_res_q ? (32'd0 - acc_q[31:0])
                           : acc_q[31:0];
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: state_d = IDLE;
    endcase

    if (cancel) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, scoreboard queue and
// hand-built cancel/reset/back-to-back sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, wr_hi, wr_lo, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic [63:0] sb_q[$];
  vec_t        vecs[12];

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .wr_hi  (wr_hi),
    .wr_lo  (wr_lo),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int exp_cyc(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    return o[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: p = 64'(sx * sy);
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) p = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          p = {32'd0, 32'h80000000};
        else p = {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFFFFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // Caller sits on a negedge; returns on the first busy negedge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh,
                        input logic [31:0] el);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    sb_q.push_back({eh, el});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int init, input int exp_n,
                           input string nm);
    int n;
    logic [63:0] e;
    n = init;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_cycles"}, 64'(n), 64'(exp_n));
    chk({nm, "_done"}, {63'd0, done}, 64'd1);
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s_sb actual=empty expected=entry", nm);
    end else begin
      checks--;
      e = sb_q.pop_front();
      chk({nm, "_hilo"}, {hi, lo}, e);
    end
  endtask

  task automatic finish_op(input string nm);
    @(negedge clk);
    chk({nm, "_pulse"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] old_lo;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    int          seen;

    vecs[0]  = '{"mult_neg1x2", 2'd0, 32'hFFFFFFFF, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{"multu_big", 2'd1, 32'hFFFFFFFF, 32'd2,
                 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{"div_m7_2", 2'd2, 32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_100_7", 2'd3, 32'd100, 32'd7,
                 32'd2, 32'd14};
    vecs[4]  = '{"divu_by0", 2'd3, 32'h1234, 32'd0,
                 32'h1234, 32'hFFFFFFFF};
    vecs[5]  = '{"div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF,
                 32'd0, 32'h80000000};
    vecs[6]  = '{"div_by0_neg", 2'd2, 32'hFFFFFFF9, 32'd0,
                 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[7]  = '{"mult_min_sq", 2'd0, 32'h80000000, 32'h80000000,
                 32'h40000000, 32'd0};
    vecs[8]  = '{"multu_max_sq", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001};
    vecs[9]  = '{"div_7_m2", 2'd2, 32'd7, 32'hFFFFFFFE,
                 32'd1, 32'hFFFFFFFD};
    vecs[10] = '{"mult_7_m3", 2'd0, 32'd7, 32'hFFFFFFFD,
                 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[11] = '{"divu_max_1", 2'd3, 32'hFFFFFFFF, 32'd1,
                 32'd0, 32'hFFFFFFFF};

    rst_n  = 1'b0;
    start  = 1'b0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    cancel = 1'b0;
    op     = 2'd0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_state", {busy, done, hi, lo}, 66'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo);
      wait_done(0, exp_cyc(vecs[i].op), vecs[i].nm);
      finish_op(vecs[i].nm);
    end

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 2 == 1) ? $urandom : 32'($urandom_range(0, 20));
      e  = model(ro, rx, ry);
      launch(ro, rx, ry, e[63:32], e[31:0]);
      wait_done(0, exp_cyc(ro), "rand");
      finish_op("rand");
    end

    // MTHI and MTLO in the same cycle
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    a     = 32'h13579BDF;
    @(negedge clk);
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    chk("mt_both", {hi, lo}, {32'h13579BDF, 32'h13579BDF});

    // start and MTHI together: FIX overwrites later
    wr_hi = 1'b1;
    launch(2'd0, 32'd3, 32'd5, 32'd0, 32'd15);
    wr_hi = 1'b0;
    chk("start_mthi_hi", {32'd0, hi}, 64'd3);
    wait_done(0, exp_cyc(2'd0), "start_mthi");
    finish_op("start_mthi");

    // start and MTLO while busy are ignored
    old_lo = lo;
    launch(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = 2'd1;
    a     = 32'hDEADBEEF;
    b     = 32'd5;
    wr_lo = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_lo = 1'b0;
    chk("mtlo_busy", {32'd0, lo}, {32'd0, old_lo});
    wait_done(5, 33, "start_busy");
    finish_op("start_busy");

    // back-to-back start in the DONE cycle
    launch(2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_done(0, 33, "b2b_a");
    launch(2'd1, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE);
    chk("b2b_busy", {62'd0, busy, done}, 64'd2);
    wait_done(0, exp_cyc(2'd1), "b2b_b");
    finish_op("b2b_b");

    // MTHI, DIV, cancel in busy cycle 10
    wr_hi = 1'b1;
    a     = 32'hAAAA5555;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi", {32'd0, hi}, 64'hAAAA5555);
    old_lo = lo;
    launch(2'd2, 32'd100, 32'd7, 32'd2, 32'd14);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_idle", {62'd0, busy, done}, 64'd0);
    chk("cancel_hilo", {hi, lo}, {32'hAAAA5555, old_lo});
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("cancel_no_done", 64'(seen), 64'd0);

    // asynchronous reset mid-operation
    launch(2'd1, 32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {busy, done, hi, lo}, 66'd0);
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch(2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_done(0, 33, "post_rst");
    finish_op("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
